// File: rtl/mux_fdbk_sync_arb_if.sv
// Request/accept and synchronizer-side signals shared by the arbiter and its environment.
// The master modport is the requester/synchronizer side; the slave modport is the arbiter.
interface mux_fdbk_sync_arb_if #(
    parameter int DWIDTH = 4,
    parameter int NREQ   = 4
);
    logic [NREQ-1:0]        i_req_valid;
    logic [NREQ*DWIDTH-1:0] i_req_data;
    logic [NREQ-1:0]        o_req_ready;
    logic [DWIDTH-1:0]      o_sync_data;
    logic                   o_sync_valid;
    logic                   i_sync_ready;

    modport master (
        output i_req_valid, i_req_data, i_sync_ready,
        input  o_req_ready, o_sync_data, o_sync_valid
    );

    modport slave (
        input  i_req_valid, i_req_data, i_sync_ready,
        output o_req_ready, o_sync_data, o_sync_valid
    );
endinterface

// File: rtl/mux_fdbk_sync_arb.sv
// Round-robin scheduler feeding one feedback-handshake synchronizer channel; one transfer is
// in flight at a time and it completes only after the channel's ready goes low and then high again.
module mux_fdbk_sync_arb #(
    parameter int DWIDTH  = 4,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64,
    parameter int CNTW    = 16,
    localparam int GW     = $clog2(NREQ),
    localparam int TW     = $clog2(TIMEOUT + 1)
) (
    input  logic                 i_src_clk,
    input  logic                 rst,
    mux_fdbk_sync_arb_if.slave   bus,
    input  logic                 i_err_clr,
    output logic                 o_busy,
    output logic [GW-1:0]        o_grant_id,
    output logic                 o_err_timeout,
    output logic [CNTW-1:0]      o_xact_cnt
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT_LO, WAIT_HI} state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     ptr_q, ptr_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic [GW-1:0]     gid_q, gid_d;
    logic              err_q, err_d;
    logic [CNTW-1:0]   xcnt_q, xcnt_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;

    logic [GW-1:0]     cand_idx [NREQ];
    logic              grant_vld;
    logic [GW-1:0]     grant_idx;
    logic              accept;
    logic              timeout_set;

    // Candidate order for this cycle: ptr, ptr+1, ... wrapping at NREQ-1.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
            logic [GW:0] sum;
            assign sum = {1'b0, ptr_q} + (GW+1)'(gi);
            assign cand_idx[gi] = (sum >= (GW+1)'(NREQ)) ? GW'(sum - (GW+1)'(NREQ)) : GW'(sum);
        end
    endgenerate

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        // Descending scan so the lowest rotation offset is the last (winning) assignment.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.i_req_valid[cand_idx[i]]) begin
                grant_vld = 1'b1;
                grant_idx = cand_idx[i];
            end
        end
    end

    // The reset term keeps the combinational accept at zero while reset is held.
    assign accept          = (state_q == IDLE) && bus.i_sync_ready && grant_vld && !rst;
    assign bus.o_req_ready = accept ? (NREQ'(1) << grant_idx) : '0;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        data_d      = data_q;
        gid_d       = gid_q;
        xcnt_d      = xcnt_q;
        tcnt_d      = tcnt_q;
        timeout_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = bus.i_req_data[grant_idx*DWIDTH +: DWIDTH];
                    gid_d   = grant_idx;
                    ptr_d   = (grant_idx == GW'(NREQ - 1)) ? '0 : grant_idx + GW'(1);
                    state_d = SEND;
                end
            end
            SEND: begin
                tcnt_d  = '0;
                state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (!bus.i_sync_ready) begin
                    tcnt_d  = tcnt_q + TW'(1);
                    state_d = WAIT_HI;
                end else if (tcnt_q >= TW'(TIMEOUT - 1)) begin
                    timeout_set = 1'b1;
                    state_d     = IDLE;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            WAIT_HI: begin
                if (bus.i_sync_ready) begin
                    xcnt_d  = xcnt_q + CNTW'(1);
                    state_d = IDLE;
                end else if (tcnt_q >= TW'(TIMEOUT - 1)) begin
                    timeout_set = 1'b1;
                    state_d     = IDLE;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        err_d = timeout_set ? 1'b1 : (i_err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge i_src_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            data_q  <= '0;
            gid_q   <= '0;
            err_q   <= 1'b0;
            xcnt_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            gid_q   <= gid_d;
            err_q   <= err_d;
            xcnt_q  <= xcnt_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign bus.o_sync_data  = data_q;
    assign bus.o_sync_valid = (state_q == SEND);
    assign o_busy           = (state_q != IDLE);
    assign o_grant_id       = gid_q;
    assign o_err_timeout    = err_q;
    assign o_xact_cnt       = xcnt_q;
endmodule

// File: doc/mux_fdbk_sync_arb.md
Name: mux_fdbk_sync_arb

Overview:
Source-domain scheduler that shares one mux_fdbk_sync channel between NREQ requesters. It arbitrates requests round-robin and captures the winner's word. It then issues a single-cycle valid pulse into the synchronizer. It holds the data stable and waits for the synchronizer's ready feedback to complete a full low-then-high cycle before it issues the next transfer. A timeout supervisor flags a feedback handshake that never completes.

Parameters:
DWIDTH, 4, payload width per requester and of the synchronizer data bus
NREQ, 4, number of requesters (2..16)
TIMEOUT, 64, max cycles allowed in WAIT_LO and WAIT_HI combined before the error flag is raised (>=4)
CNTW, 16, width of the completed-transfer counter

Ports:
i_src_clk  in  1  source clock; the only clock in the block
rst  in  1  asynchronous, active-high reset
i_req_valid  in  NREQ  per-requester request, held high until accepted
i_req_data  in  NREQ*DWIDTH  requester k drives bits [k*DWIDTH +: DWIDTH]
o_req_ready  out  NREQ  one-hot, one-cycle accept pulse to the winning requester
o_sync_data  out  DWIDTH  payload to synchronizer i_src_data
o_sync_valid  out  1  one-cycle pulse to synchronizer i_src_valid
i_sync_ready  in  1  synchronizer o_dst_ready feedback (high = channel idle)
o_busy  out  1  high in every state except IDLE
o_grant_id  out  $clog2(NREQ)  index of the last accepted requester
o_err_timeout  out  1  sticky handshake-timeout flag
i_err_clr  in  1  clears o_err_timeout
o_xact_cnt  out  CNTW  number of completed transfers; wraps modulo 2^CNTW

Behaviour:
- Reset: every output is 0. The FSM goes to IDLE and the RR pointer is 0, so requester 0 has top priority.
- Reset acts immediately and asynchronously, including mid-transfer. o_sync_valid drops at once and no accept or count event is produced.
- IDLE:
  - When i_sync_ready=1 and at least one i_req_valid bit is set, grant the first set bit searching from ptr, ptr+1, ... and wrapping at NREQ-1→0.
  - In the same cycle: o_req_ready[g]=1, o_sync_data<=i_req_data[g], o_grant_id<=g, ptr<=(g+1) mod NREQ. Go to SEND.
  - When i_sync_ready=0, no grant is made, whatever the request state.
- SEND: o_sync_valid=1 for exactly this one cycle. Clear the timeout counter and go to WAIT_LO.
- WAIT_LO: wait for i_sync_ready=0, then go to WAIT_HI. Increment the timeout counter.
- WAIT_HI: wait for i_sync_ready=1, then go to IDLE and increment o_xact_cnt. Increment the timeout counter.
- Timeout:
  - The counter is shared between WAIT_LO and WAIT_HI and is not cleared between them.
  - When the counter reaches TIMEOUT-1 with no completing transition, set o_err_timeout, go to IDLE and do not increment o_xact_cnt.
  - IDLE then holds off the next grant until i_sync_ready=1.
- o_sync_data is registered and changes only on an accept. It is stable from SEND until the next accept, which guarantees the mux-sync data-stability requirement.
- Latency:
  - Accept to o_sync_valid: 1 cycle.
  - Minimum accept-to-accept spacing: 4 cycles (IDLE, SEND, WAIT_LO, WAIT_HI), plus the synchronizer's round-trip time.
- o_req_ready is combinational from the IDLE state, i_sync_ready, i_req_valid and ptr. Requesters must not drop i_req_valid before their accept.
- If i_err_clr and a new timeout occur in the same cycle, the set wins.
- A requester that deasserts i_req_valid without being accepted is simply skipped.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NREQ-1,0.
- o_xact_cnt wraps from 2^CNTW-1 to 0 without a flag.

Test Plan:
- Single requester: after reset, requester 2 sends 0xA while i_sync_ready=1. Expect:
  - o_req_ready=4'b0100 for 1 cycle and o_sync_valid one cycle later with o_sync_data=0xA.
  - After ready goes 1→0→1: o_xact_cnt=1, o_busy=0, o_grant_id=2.
- Round-robin: all 4 requesters held valid with data 0x1..0x4, behind a real mux_fdbk_sync (fast→slow and slow→fast) for 8 transfers. Expect:
  - Grant order 0,1,2,3,0,1,2,3 and destination data sequence 1,2,3,4,1,2,3,4.
  - Zero mismatches and o_xact_cnt=8.
- Ready stuck high: i_sync_ready is held at 1 after a SEND. Expect o_err_timeout=1 exactly TIMEOUT cycles after SEND, the FSM back in IDLE, and o_xact_cnt unchanged.
- Ready stuck low: ready drops and never returns. Expect:
  - The timeout fires, and no further grant is made while ready=0 even with requests pending.
  - Once ready=1, the next grant proceeds.
  - Asserting i_err_clr on the same cycle as a fresh timeout leaves the flag set.
- Reset mid-transfer: assert rst during WAIT_HI. Expect:
  - All outputs 0 asynchronously.
  - After release, requester 0 wins first even though ptr had advanced to 3.
- Counter wrap: CNTW=4, 17 transfers. Expect o_xact_cnt=1 and data intact.
